// File: rtl/role_intr_pkg.sv
// Shared definitions for the shell-to-role interrupt controller: register map,
// AXI response codes, FSM state types and the address decoder.
package role_intr_pkg;

   localparam logic [11:0] PEND_OFF = 12'h000;
   localparam logic [11:0] EN_OFF   = 12'h100;
   localparam logic [11:0] MODE_OFF = 12'h200;
   localparam logic [11:0] ACT_OFF  = 12'h300;
   localparam logic [11:0] RAW_OFF  = 12'h400;
   localparam logic [11:0] CTRL_OFF = 12'h800;
   localparam logic [11:0] INFO_OFF = 12'h804;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_e;
   typedef enum logic       {R_IDLE, R_DATA} rd_state_e;

   typedef enum logic [2:0] {
      SEL_PEND, SEL_EN, SEL_MODE, SEL_ACT, SEL_RAW, SEL_CTRL, SEL_INFO, SEL_NONE
   } reg_sel_e;

   function automatic int num_banks(input int n);
      return (n + 31) / 32;
   endfunction

   // widx is the 32-bit word index, i.e. offset[11:2]; byte lanes are ignored.
   function automatic reg_sel_e decode_sel(input logic [9:0] widx, input int nb);
      reg_sel_e   sel;
      logic [11:0] word;
      word = {widx, 2'b00};
      sel  = SEL_NONE;
      if (word == CTRL_OFF) begin
         sel = SEL_CTRL;
      end else if (word == INFO_OFF) begin
         sel = SEL_INFO;
      end else if (int'(widx[5:0]) < nb) begin
         case (widx[9:6])
            PEND_OFF[11:8]: sel = SEL_PEND;
            EN_OFF[11:8]:   sel = SEL_EN;
            MODE_OFF[11:8]: sel = SEL_MODE;
            ACT_OFF[11:8]:  sel = SEL_ACT;
            RAW_OFF[11:8]:  sel = SEL_RAW;
            default:        sel = SEL_NONE;
         endcase
      end
      return sel;
   endfunction

endpackage

// File: rtl/role_intr_ctrl_if.sv
// AXI4-Lite control channel bundle between the shell master and the
// interrupt controller register block.
interface role_intr_ctrl_if #(
   parameter int ADDR_W = 20
);
   logic [ADDR_W-1:0] awaddr;
   logic [2:0]        awprot;
   logic              awvalid;
   logic              awready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic [2:0]        arprot;
   logic              arvalid;
   logic              arready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/role_intr_prio_enc.sv
// Lowest-set-bit priority encoder: index 0 wins; id is 0 when nothing is set.
module role_intr_prio_enc #(
   parameter int NUM_IRQ = 64,
   parameter int ID_W    = 7
) (
   input  logic [NUM_IRQ-1:0] req,
   output logic [ID_W-1:0]    id,
   output logic               valid
);

   always_comb begin
      id    = '0;
      valid = 1'b0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            id    = ID_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/role_intr_ctrl.sv
// Shell-to-role interrupt controller with AXI4-Lite register access.
// Optional event coalescing on irq_out is built when INTR_COALESCE_EN is defined.
module role_intr_ctrl
   import role_intr_pkg::*;
#(
   parameter int                NUM_IRQ   = 64,
   parameter int                ADDR_W    = 20,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                ID_W      = 7
) (
   input  logic               aclk,
   input  logic               aresetn,
   input  logic [NUM_IRQ-1:0] s2r_intr,
   role_intr_ctrl_if.slave    s_axi_ctrl,
   output logic               irq_out,
   output logic [ID_W-1:0]    irq_id,
   output wr_state_e          wr_state_dbg,
   output rd_state_e          rd_state_dbg
);

   localparam int          NB       = num_banks(NUM_IRQ);
   localparam int          VEC_W    = NB * 32;
   localparam logic [31:0] INFO_VAL = {16'h0001, 16'(NUM_IRQ)};

`ifdef INTR_COALESCE_EN
   localparam logic [31:0] CTRL_MASK = 32'hFFFF_FF01;
`else
   localparam logic [31:0] CTRL_MASK = 32'h0000_0001;
`endif

   // Handshakes: a beat transfers on the rising edge where valid and ready are
   // both high; a source holds valid and its payload steady until then, and
   // every ready/valid driven here is a register.

   wr_state_e         wr_state;
   rd_state_e         rd_state;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [31:0]       wr_data_q;
   logic [3:0]        wr_strb_q;
   logic              wr_go;
   logic              aw_hs, w_hs, ar_hs;

   logic [NUM_IRQ-1:0] pending, enable, mode, prev;
   logic [NUM_IRQ-1:0] rise, active, pend_clr, wd, wm;
   logic [31:0]        ctrl_q;

   reg_sel_e    wr_sel, rd_sel;
   logic [5:0]  wr_bank, rd_bank;
   logic [31:0] wr_mask32;
   logic        wr_pend, wr_en_reg, wr_mode_reg, wr_ctrl;

   logic [VEC_W-1:0] rd_vec;
   logic [31:0]      rd_data_c;
   logic             rd_err_c;

   logic [ID_W-1:0] enc_id;
   logic            enc_valid;
   logic            irq_cond;

   logic unused_ok;

   assign aw_hs = s_axi_ctrl.awvalid & s_axi_ctrl.awready;
   assign w_hs  = s_axi_ctrl.wvalid & s_axi_ctrl.wready;
   assign ar_hs = s_axi_ctrl.arvalid & s_axi_ctrl.arready;

   assign wr_state_dbg = wr_state;
   assign rd_state_dbg = rd_state;

   assign unused_ok = ^{s_axi_ctrl.awprot, s_axi_ctrl.arprot,
                        wr_addr_q[1:0], s_axi_ctrl.araddr[1:0]};

   // ---------------- address decode ----------------
   assign wr_sel  = (wr_addr_q[ADDR_W-1:12] == BASE_ADDR[ADDR_W-1:12])
                    ? decode_sel(wr_addr_q[11:2], NB) : SEL_NONE;
   assign rd_sel  = (s_axi_ctrl.araddr[ADDR_W-1:12] == BASE_ADDR[ADDR_W-1:12])
                    ? decode_sel(s_axi_ctrl.araddr[11:2], NB) : SEL_NONE;
   assign wr_bank = wr_addr_q[7:2];
   assign rd_bank = s_axi_ctrl.araddr[7:2];

   assign wr_mask32 = {{8{wr_strb_q[3]}}, {8{wr_strb_q[2]}},
                       {8{wr_strb_q[1]}}, {8{wr_strb_q[0]}}};
   // Place the written word on its bank; bits at or above NUM_IRQ fall off here.
   assign wd = NUM_IRQ'(VEC_W'(wr_data_q) << {wr_bank, 5'b0});
   assign wm = NUM_IRQ'(VEC_W'(wr_mask32) << {wr_bank, 5'b0});

   assign wr_pend     = wr_go && (wr_sel == SEL_PEND);
   assign wr_en_reg   = wr_go && (wr_sel == SEL_EN);
   assign wr_mode_reg = wr_go && (wr_sel == SEL_MODE);
   assign wr_ctrl     = wr_go && (wr_sel == SEL_CTRL);

   // ---------------- write FSM ----------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_state           <= W_IDLE;
         wr_addr_q          <= '0;
         wr_data_q          <= '0;
         wr_strb_q          <= '0;
         wr_go              <= 1'b0;
         s_axi_ctrl.awready <= 1'b0;
         s_axi_ctrl.wready  <= 1'b0;
         s_axi_ctrl.bvalid  <= 1'b0;
         s_axi_ctrl.bresp   <= AXI_RESP_OKAY;
      end else begin
         case (wr_state)
            W_IDLE: begin
               s_axi_ctrl.awready <= 1'b1;
               s_axi_ctrl.wready  <= 1'b1;
               if (aw_hs) wr_addr_q <= s_axi_ctrl.awaddr;
               if (w_hs) begin
                  wr_data_q <= s_axi_ctrl.wdata;
                  wr_strb_q <= s_axi_ctrl.wstrb;
               end
               if (aw_hs && w_hs) begin
                  s_axi_ctrl.awready <= 1'b0;
                  s_axi_ctrl.wready  <= 1'b0;
                  wr_go              <= 1'b1;
                  wr_state           <= W_RESP;
               end else if (aw_hs) begin
                  s_axi_ctrl.awready <= 1'b0;
                  wr_state           <= W_HAVE_AW;
               end else if (w_hs) begin
                  s_axi_ctrl.wready  <= 1'b0;
                  wr_state           <= W_HAVE_W;
               end
            end
            W_HAVE_AW: begin
               if (w_hs) begin
                  wr_data_q         <= s_axi_ctrl.wdata;
                  wr_strb_q         <= s_axi_ctrl.wstrb;
                  s_axi_ctrl.wready <= 1'b0;
                  wr_go             <= 1'b1;
                  wr_state          <= W_RESP;
               end
            end
            W_HAVE_W: begin
               if (aw_hs) begin
                  wr_addr_q          <= s_axi_ctrl.awaddr;
                  s_axi_ctrl.awready <= 1'b0;
                  wr_go              <= 1'b1;
                  wr_state           <= W_RESP;
               end
            end
            W_RESP: begin
               // wr_go is the single register-update cycle; the response follows it.
               if (wr_go) begin
                  wr_go             <= 1'b0;
                  s_axi_ctrl.bvalid <= 1'b1;
                  s_axi_ctrl.bresp  <= (wr_sel == SEL_NONE) ? AXI_RESP_SLVERR
                                                            : AXI_RESP_OKAY;
               end else if (s_axi_ctrl.bvalid && s_axi_ctrl.bready) begin
                  s_axi_ctrl.bvalid  <= 1'b0;
                  s_axi_ctrl.bresp   <= AXI_RESP_OKAY;
                  s_axi_ctrl.awready <= 1'b1;
                  s_axi_ctrl.wready  <= 1'b1;
                  wr_state           <= W_IDLE;
               end
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

   // ---------------- read path ----------------
   always_comb begin
      rd_vec = '0;
      case (rd_sel)
         SEL_PEND: rd_vec = VEC_W'(pending);
         SEL_EN:   rd_vec = VEC_W'(enable);
         SEL_MODE: rd_vec = VEC_W'(mode);
         SEL_ACT:  rd_vec = VEC_W'(active);
         SEL_RAW:  rd_vec = VEC_W'(s2r_intr);
         default:  rd_vec = '0;
      endcase
      rd_data_c = 32'(rd_vec >> {rd_bank, 5'b0});
      rd_err_c  = 1'b0;
      case (rd_sel)
         SEL_CTRL: rd_data_c = ctrl_q;
         SEL_INFO: rd_data_c = INFO_VAL;
         SEL_NONE: begin
            rd_data_c = '0;
            rd_err_c  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_state           <= R_IDLE;
         s_axi_ctrl.arready <= 1'b0;
         s_axi_ctrl.rvalid  <= 1'b0;
         s_axi_ctrl.rdata   <= '0;
         s_axi_ctrl.rresp   <= AXI_RESP_OKAY;
      end else begin
         case (rd_state)
            R_IDLE: begin
               s_axi_ctrl.arready <= 1'b1;
               if (ar_hs) begin
                  s_axi_ctrl.arready <= 1'b0;
                  s_axi_ctrl.rvalid  <= 1'b1;
                  s_axi_ctrl.rdata   <= rd_data_c;
                  s_axi_ctrl.rresp   <= rd_err_c ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                  rd_state           <= R_DATA;
               end
            end
            R_DATA: begin
               if (s_axi_ctrl.rready) begin
                  s_axi_ctrl.rvalid  <= 1'b0;
                  s_axi_ctrl.arready <= 1'b1;
                  rd_state           <= R_IDLE;
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

   // ---------------- interrupt state ----------------
   assign rise     = s2r_intr & ~prev;
   assign active   = pending & enable;
   assign pend_clr = wr_pend ? (wd & wm) : '0;

   // Edge sources: a new rise wins over a same-cycle clear. Level sources track the input.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pending <= '0;
         enable  <= '0;
         mode    <= '1;
         prev    <= '0;
         ctrl_q  <= '0;
      end else begin
         prev    <= s2r_intr;
         pending <= (mode & ((pending & ~pend_clr) | rise)) | (~mode & s2r_intr);
         if (wr_en_reg)   enable <= (enable & ~wm) | (wd & wm);
         if (wr_mode_reg) mode   <= (mode & ~wm) | (wd & wm);
         if (wr_ctrl)
            ctrl_q <= ((ctrl_q & ~wr_mask32) | (wr_data_q & wr_mask32)) & CTRL_MASK;
      end
   end

   role_intr_prio_enc #(
      .NUM_IRQ (NUM_IRQ),
      .ID_W    (ID_W)
   ) u_prio_enc (
      .req   (active),
      .id    (enc_id),
      .valid (enc_valid)
   );

`ifdef INTR_COALESCE_EN
   logic [7:0]  coal_cnt;
   logic [15:0] coal_timer;
   logic [7:0]  coal_thr;
   logic        coal_new;

   assign coal_thr = (ctrl_q[15:8] == 8'd0) ? 8'd1 : ctrl_q[15:8];
   assign coal_new = |(rise & mode & enable & ~pending);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         coal_cnt   <= '0;
         coal_timer <= '0;
      end else begin
         if (!enc_valid && !coal_new)                coal_cnt <= '0;
         else if (coal_new && coal_cnt != 8'hFF)     coal_cnt <= coal_cnt + 8'd1;
         if (!enc_valid)                             coal_timer <= '0;
         else if (coal_timer != 16'hFFFF)            coal_timer <= coal_timer + 16'd1;
      end
   end

   assign irq_cond = enc_valid &&
                     ((coal_cnt >= coal_thr) || (coal_timer >= ctrl_q[31:16]));
`else
   assign irq_cond = enc_valid;
`endif

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         irq_out <= 1'b0;
         irq_id  <= '0;
      end else begin
         irq_out <= ctrl_q[0] & irq_cond;
         irq_id  <= (ctrl_q[0] && enc_valid) ? enc_id : '0;
      end
   end

endmodule

// File: tb/tb_role_intr_ctrl.sv
// Directed bench for role_intr_ctrl (NUM_IRQ=64); coalescing steps run only
// when INTR_COALESCE_EN is defined.
module tb_role_intr_ctrl;
   import role_intr_pkg::*;

   logic        aclk;
   logic        aresetn;
   logic [63:0] s2r;
   logic        irq_out;
   logic [6:0]  irq_id;
   wr_state_e   wr_state_dbg;
   rd_state_e   rd_state_dbg;

   int n_cmp = 0;
   int n_err = 0;

   role_intr_ctrl_if #(.ADDR_W(20)) axi ();

   role_intr_ctrl #(
      .NUM_IRQ   (64),
      .ADDR_W    (20),
      .BASE_ADDR (20'h0),
      .ID_W      (7)
   ) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .s2r_intr     (s2r),
      .s_axi_ctrl   (axi.slave),
      .irq_out      (irq_out),
      .irq_id       (irq_id),
      .wr_state_dbg (wr_state_dbg),
      .rd_state_dbg (rd_state_dbg)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   task automatic axi_write(input logic [19:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      bit aw_done, w_done, aw_now, w_now, b_done;
      axi.awaddr = addr; axi.awvalid = 1'b1;
      axi.wdata  = data; axi.wstrb   = strb; axi.wvalid = 1'b1;
      aw_done = 1'b0; w_done = 1'b0;
      for (int c = 0; c < 50 && !(aw_done && w_done); c++) begin
         aw_now = axi.awvalid && axi.awready;
         w_now  = axi.wvalid && axi.wready;
         tick(1);
         if (aw_now) begin aw_done = 1'b1; axi.awvalid = 1'b0; end
         if (w_now)  begin w_done  = 1'b1; axi.wvalid  = 1'b0; end
      end
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      check("wr_aw_w_accept", {30'd0, aw_done, w_done}, 32'd3);
      axi.bready = 1'b1; b_done = 1'b0; resp = 2'b11;
      for (int c = 0; c < 50 && !b_done; c++) begin
         if (axi.bvalid) begin b_done = 1'b1; resp = axi.bresp; end
         tick(1);
      end
      axi.bready = 1'b0;
      check("wr_bvalid_seen", {31'd0, b_done}, 32'd1);
   endtask

   task automatic axi_read(input logic [19:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      bit done;
      axi.araddr = addr; axi.arvalid = 1'b1; done = 1'b0;
      for (int c = 0; c < 50 && !done; c++) begin
         done = axi.arready;
         tick(1);
      end
      axi.arvalid = 1'b0;
      check("rd_ar_accept", {31'd0, done}, 32'd1);
      axi.rready = 1'b1; done = 1'b0; data = 32'hDEAD_BEEF; resp = 2'b11;
      for (int c = 0; c < 50 && !done; c++) begin
         if (axi.rvalid) begin done = 1'b1; data = axi.rdata; resp = axi.rresp; end
         tick(1);
      end
      axi.rready = 1'b0;
      check("rd_rvalid_seen", {31'd0, done}, 32'd1);
   endtask

   task automatic pulse(input int idx);
      s2r[idx] = 1'b1;
      tick(1);
      s2r[idx] = 1'b0;
      tick(1);
   endtask

   logic [31:0] rd;
   logic [1:0]  rs, bs;
   int          hold_cnt;
   bit          seen;

   initial begin
      aresetn = 1'b0; s2r = '0;
      axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
      axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
      axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

      // Reset state
      tick(3);
      check("rst_irq_out", {31'd0, irq_out}, 32'd0);
      check("rst_irq_id", {25'd0, irq_id}, 32'd0);
      check("rst_awready", {31'd0, axi.awready}, 32'd0);
      check("rst_bvalid", {31'd0, axi.bvalid}, 32'd0);
      check("rst_rvalid_rdata", {axi.rvalid, axi.rdata[30:0]}, 32'd0);
      check("rst_wr_state", 32'(wr_state_dbg), 32'(W_IDLE));
      aresetn = 1'b1;
      tick(1);

      // INFO and empty PENDING
      axi_read(20'h804, rd, rs);
      check("info_data", rd, 32'h0001_0040);
      check("info_resp", {30'd0, rs}, 32'd0);
      axi_read(20'h000, rd, rs);
      check("pend0_reset", rd, 32'd0);
      check("mode0_reset_irq", {31'd0, irq_out}, 32'd0);
      axi_read(20'h200, rd, rs);
      check("mode0_reset", rd, 32'hFFFF_FFFF);

      // Byte strobe: only lane 0 lands
      axi_write(20'h100, 32'hFFFF_FF2C, 4'b0001, bs);
      check("en0_wr_resp", {30'd0, bs}, 32'd0);
      axi_read(20'h100, rd, rs);
      check("en0_strobe", rd, 32'h0000_002C);
      axi_write(20'h104, 32'h0000_0100, 4'hF, bs);
      axi_write(20'h800, 32'hFFFF_FFFF, 4'hF, bs);
      axi_read(20'h800, rd, rs);
`ifdef INTR_COALESCE_EN
      check("ctrl_mask", rd, 32'hFFFF_FF01);
`else
      check("ctrl_mask", rd, 32'h0000_0001);
`endif
      axi_write(20'h800, 32'h0000_0001, 4'hF, bs);

      // Single-cycle pulse on bit 5
      s2r[5] = 1'b1;
      tick(1);
      s2r[5] = 1'b0;
      check("pulse5_irq_lat1", {31'd0, irq_out}, 32'd0);
      tick(1);
      check("pulse5_irq_lat2", {31'd0, irq_out}, 32'd1);
      check("pulse5_id", {25'd0, irq_id}, 32'd5);
      axi_read(20'h000, rd, rs);
      check("pulse5_pend", rd, 32'h0000_0020);
      axi_write(20'h000, 32'h0000_0020, 4'hF, bs);
      check("w1c5_irq_drop", {31'd0, irq_out}, 32'd0);

      // Priority between bits 3 and 40
      s2r[3] = 1'b1; s2r[40] = 1'b1;
      tick(1);
      s2r[3] = 1'b0; s2r[40] = 1'b0;
      tick(2);
      check("prio_id_3", {25'd0, irq_id}, 32'd3);
      axi_write(20'h000, 32'h0000_0008, 4'hF, bs);
      check("prio_id_40", {25'd0, irq_id}, 32'd40);
      check("prio_irq_40", {31'd0, irq_out}, 32'd1);
      axi_write(20'h004, 32'h0000_0100, 4'hF, bs);
      check("prio_clear_all_id", {25'd0, irq_id}, 32'd0);

      // Rising edge in the same cycle as the W1C commit
      check("race_ready", {30'd0, axi.awready, axi.wready}, 32'd3);
      axi.awaddr = 20'h000; axi.awvalid = 1'b1;
      axi.wdata = 32'h0000_0020; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
      tick(1);
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      s2r[5] = 1'b1;
      tick(1);
      s2r[5] = 1'b0;
      check("race_commit_bvalid", {31'd0, axi.bvalid}, 32'd1);
      axi.bready = 1'b1;
      tick(1);
      axi.bready = 1'b0;
      axi_read(20'h000, rd, rs);
      check("race_pend5_kept", rd, 32'h0000_0020);
      axi_write(20'h000, 32'h0000_0020, 4'hF, bs);

      // Level mode on bit 2
      axi_write(20'h200, 32'hFFFF_FFFB, 4'hF, bs);
      s2r[2] = 1'b1;
      tick(2);
      check("lvl_irq", {31'd0, irq_out}, 32'd1);
      check("lvl_id", {25'd0, irq_id}, 32'd2);
      axi_write(20'h000, 32'h0000_0004, 4'hF, bs);
      axi_read(20'h000, rd, rs);
      check("lvl_w1c_ignored", rd, 32'h0000_0004);
      s2r[2] = 1'b0;
      tick(1);
      check("lvl_drop_lat1", {31'd0, irq_out}, 32'd1);
      tick(1);
      check("lvl_drop_lat2", {31'd0, irq_out}, 32'd0);

      // W three cycles ahead of AW, response held off by bready
      axi.wdata = 32'h0000_0300; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
      tick(1);
      axi.wvalid = 1'b0;
      check("split_have_w", 32'(wr_state_dbg), 32'(W_HAVE_W));
      tick(2);
      axi.awaddr = 20'h104; axi.awvalid = 1'b1;
      tick(1);
      axi.awvalid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         if (axi.bvalid) seen = 1'b1;
         else tick(1);
      end
      check("split_bvalid_seen", {31'd0, seen}, 32'd1);
      check("split_awready_blocked", {31'd0, axi.awready}, 32'd0);
      hold_cnt = 0;
      repeat (4) begin
         if (axi.bvalid) hold_cnt++;
         tick(1);
      end
      check("split_bvalid_held", 32'(hold_cnt), 32'd4);
      check("split_bresp", {30'd0, axi.bresp}, 32'd0);
      axi.bready = 1'b1;
      tick(1);
      axi.bready = 1'b0;
      check("split_bvalid_done", {31'd0, axi.bvalid}, 32'd0);
      axi_read(20'h104, rd, rs);
      check("split_en1", rd, 32'h0000_0300);

      // Unmapped offsets
      axi_write(20'h900, 32'h1234_5678, 4'hF, bs);
      check("unmap_wr_resp", {30'd0, bs}, 32'd2);
      axi_read(20'h900, rd, rs);
      check("unmap_rd_data", rd, 32'd0);
      check("unmap_rd_resp", {30'd0, rs}, 32'd2);
      axi_read(20'h008, rd, rs);
      check("bank2_rd_resp", {30'd0, rs}, 32'd2);

      // RAW and ACTIVE against pending on disabled bits
      s2r[0] = 1'b1; s2r[31] = 1'b1;
      tick(1);
      axi_read(20'h400, rd, rs);
      check("raw0", rd, 32'h8000_0001);
      s2r[0] = 1'b0; s2r[31] = 1'b0;
      axi_read(20'h300, rd, rs);
      check("act0_disabled", rd, 32'd0);
      axi_read(20'h000, rd, rs);
      check("pend0_disabled", rd, 32'h8000_0001);
      check("irq_disabled", {31'd0, irq_out}, 32'd0);
      axi_write(20'h000, 32'h8000_0001, 4'hF, bs);

`ifdef INTR_COALESCE_EN
      // threshold 3, timeout 100
      axi_write(20'h800, 32'h0064_0301, 4'hF, bs);
      pulse(3);
      pulse(5);
      tick(56);
      check("coal_wait_no_irq", {31'd0, irq_out}, 32'd0);
      tick(45);
      check("coal_timeout_irq", {31'd0, irq_out}, 32'd1);
      axi_write(20'h000, 32'h0000_0028, 4'hF, bs);
      tick(2);
      pulse(3);
      pulse(5);
      check("coal_two_no_irq", {31'd0, irq_out}, 32'd0);
      pulse(40);
      check("coal_three_irq", {31'd0, irq_out}, 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/role_intr_ctrl.md
Name: role_intr_ctrl

Overview:
- Parametrised shell-to-role interrupt controller that generalises the fixed 64-bit rising-edge s2r_intr vector to NUM_IRQ sources.
- Per-source edge/level mode, enable, pending and write-1-to-clear control, through an AXI4-Lite slave on the role control window.
- Drives one aggregated level interrupt and the lowest-numbered active source ID to role logic.

Parameters:
- NUM_IRQ, 64, number of interrupt sources (1..128).
- ADDR_W, 20, AXI-Lite address width, same as s_axi_ctrl.
- BASE_ADDR, 20'h0, register block base; addr[11:0] is the offset.
- ID_W, 7, width of irq_id; must be >= clog2(NUM_IRQ).

Ports:
- aclk, in, 1, sole clock.
- aresetn, in, 1, asynchronous active-low reset.
- s2r_intr, in, NUM_IRQ, interrupt sources, synchronous to aclk.
- s_axi_ctrl_awaddr/awprot/awvalid/awready, AXI-Lite AW channel (ADDR_W/3/1/1).
- s_axi_ctrl_wdata/wstrb/wvalid/wready, AXI-Lite W channel (32/4/1/1).
- s_axi_ctrl_bresp/bvalid/bready, AXI-Lite B channel (2/1/1).
- s_axi_ctrl_araddr/arprot/arvalid/arready, AXI-Lite AR channel (ADDR_W/3/1/1).
- s_axi_ctrl_rdata/rresp/rvalid/rready, AXI-Lite R channel (32/2/1/1).
- irq_out, out, 1, aggregated level interrupt.
- irq_id, out, ID_W, lowest index with active = pending & enable; 0 when none.

Behaviour:
- Registers, 32-bit words, bank i = 0..ceil(NUM_IRQ/32)-1:
  - PENDING 0x000+4i: RW1C.
  - ENABLE 0x100+4i: RW.
  - MODE 0x200+4i: RW; 1 = edge, 0 = level.
  - ACTIVE 0x300+4i: RO.
  - RAW 0x400+4i: RO, s2r_intr.
  - CTRL 0x800: bit0 global enable, RW.
  - INFO 0x804: RO, {16'h0001, NUM_IRQ[15:0]}.
- Bits at or above NUM_IRQ read 0 and ignore writes.
- Reset values: PENDING=0, ENABLE=0, MODE=all 1, CTRL=0, prev=0, irq_out=0, irq_id=0, all ready/valid=0, bresp=rresp=0, rdata=0.
- Edge mode:
  - Pending sets at the clock edge where s2r_intr=1 and prev=0; prev is registered every cycle.
  - Set takes priority over a W1C of the same bit in the same cycle.
- Level mode: pending = s2r_intr registered each cycle; W1C has no effect.
- irq_out and irq_id are registered: asserted one cycle after pending sets, i.e. 2 cycles after the rising input is sampled. Gated by CTRL.bit0.
- irq_id uses a priority encoder; index 0 is highest priority.
- Write path:
  - AW and W are accepted independently: each ready is high in IDLE until that channel is captured.
  - Once both are held, the register update occurs in one cycle, honouring wstrb per byte.
  - bvalid is raised the next cycle and held until bready. No new AW/W is accepted while bvalid=1 (one write outstanding).
- Read path: arready=1 when rvalid=0. rdata/rvalid are registered one cycle after the AR handshake; rvalid is held until rready.
- Unmapped offsets: reads return 0 with rresp=2'b10 (SLVERR); writes are dropped with bresp=2'b10.
- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP. Read FSM states: R_IDLE, R_DATA.
- Reset mid-transaction: both FSMs abort to idle and no response is issued. Masters must re-issue.

Optional Feature:
- Macro INTR_COALESCE_EN.
- With it:
  - CTRL[15:8] = count threshold (0 treated as 1).
  - CTRL[31:16] = timeout in cycles.
  - An 8-bit counter increments on each new edge pending set while any ACTIVE bit is set. irq_out asserts when count >= threshold, or when the 16-bit timer reaches the timeout while active!=0.
  - Counter and timer clear when ACTIVE becomes all zero.
  - The timer saturates.
- Without it: CTRL[31:1] read 0, and irq_out follows the base rule.

Decomposition:
- Package role_intr_pkg:
  - Register offsets: PEND_OFF, EN_OFF, MODE_OFF, ACT_OFF, RAW_OFF, CTRL_OFF, INFO_OFF.
  - AXI_RESP_OKAY/SLVERR.
  - Write/read FSM state enums.
  - NUM_BANKS function.
- One sub-module: role_intr_prio_enc, a parametrised lowest-set-bit encoder (NUM_IRQ in, ID_W plus valid out).

Test Plan:
- Reset, then read INFO: rdata=32'h0001_0040, rresp=0. Read PENDING0 = 0; irq_out=0.
- Write ENABLE0=1 and CTRL=1, then pulse s2r_intr[5] for 1 cycle: PENDING0 reads 0x20, irq_out=1 two cycles after the pulse, irq_id=5. W1C 0x20 → irq_out drops one cycle after bresp.
- Edges on bits 3 and 40 with both enabled: irq_id=3. Clear bit 3 → irq_id=40.
- W1C of bit 5 in the same cycle as a new rising edge on bit 5: PENDING bit 5 stays 1.
- MODE0 bit2=0 and s2r_intr[2] held high: pending follows the input; W1C is ignored. Input low → irq_out=0 two cycles later.
- W issued 3 cycles before AW, bready held low for 4 cycles: a single bvalid that stays until bready. Read of offset 0x900: rresp=2'b10, rdata=0.
- (INTR_COALESCE_EN) threshold=3, timeout=100: 2 edges give no irq_out until cycle 100 after the first; 3 edges give irq_out immediately.
